// File: rtl/div_clk_monitor.sv
// ---------------------------------------------------------------------------
// div_clk_monitor
//
// Watches the divided clock produced by the programmable clock divider. The
// divided clock is sampled as ordinary data in the source clock domain (it is
// generated from clk, so no synchronizer is needed).
//
// Outputs:
//   - single-cycle rise/fall ticks for logic clocked by clk
//   - high, low and full-period lengths, in source-clock samples
//   - a lock indication after LOCK_CNT identical measurements in a row
//   - a sticky timeout flag when a phase outlasts the run counter
//
// Parameters:
//   CNT_W    width of the run counter and of high_len/low_len
//   LOCK_CNT identical consecutive measurements needed for lock (1..15)
//
// Ports:
//   clk         source clock
//   rst_n       asynchronous active-low reset
//   en          monitor enable; low returns the monitor to idle on the next edge
//   div_clk     divided clock, sampled as data
//   rise_tick   one-cycle pulse per detected 0->1 of div_clk
//   fall_tick   one-cycle pulse per detected 1->0 of div_clk
//   high_len    last complete high-phase length
//   low_len     last complete low-phase length
//   period_len  high_len + low_len of the last complete period
//   meas_valid  one-cycle pulse when the three lengths update
//   locked      measurement stable
//   timeout     sticky: a phase exceeded the counter range (cleared by en=0)
// ---------------------------------------------------------------------------
module div_clk_monitor #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_clk,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic [CNT_W:0]   period_len,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] RUN_MAX  = '1;
    localparam logic [CNT_W-1:0] RUN_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);

    logic [1:0]       state_reg,      state_next;
    logic             s_reg;
    logic [CNT_W-1:0] run_reg,        run_next;
    logic [CNT_W-1:0] hi_tmp_reg,     hi_tmp_next;
    logic [CNT_W-1:0] high_len_reg,   high_len_next;
    logic [CNT_W-1:0] low_len_reg,    low_len_next;
    logic [CNT_W:0]   period_len_reg, period_len_next;
    logic [3:0]       match_reg,      match_next;
    logic             locked_reg,     locked_next;
    logic             timeout_reg,    timeout_next;
    logic             mv_reg,         mv_next;
    logic             rise_tick_reg,  rise_tick_next;
    logic             fall_tick_reg,  fall_tick_next;

    logic             rise;
    logic             fall;
    logic             same_meas;
    logic [3:0]       match_upd;

    // Edge detection against the previous sample.
    assign rise = div_clk & ~s_reg;
    assign fall = ~div_clk & s_reg;

    // The period being closed equals the previously published one. A zero
    // match count means nothing has been measured since arming, so the stale
    // lengths left over from an earlier run must not count as a match.
    assign same_meas = (match_reg != 4'd0)
                    && (hi_tmp_reg == high_len_reg)
                    && (run_reg == low_len_reg);

    always_comb begin
        state_next      = state_reg;
        run_next        = run_reg;
        hi_tmp_next     = hi_tmp_reg;
        high_len_next   = high_len_reg;
        low_len_next    = low_len_reg;
        period_len_next = period_len_reg;
        match_next      = match_reg;
        locked_next     = locked_reg;
        timeout_next    = timeout_reg;
        mv_next         = 1'b0;
        rise_tick_next  = rise & (state_reg != ST_IDLE);
        fall_tick_next  = fall & (state_reg != ST_IDLE);
        match_upd       = 4'd1;

        if (!en) begin
            // Disable dominates everything, including a phase ending this
            // cycle. The published lengths are deliberately kept.
            state_next     = ST_IDLE;
            run_next       = '0;
            match_next     = 4'd0;
            locked_next    = 1'b0;
            timeout_next   = 1'b0;
            rise_tick_next = 1'b0;
            fall_tick_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_ARM;
                end
                ST_ARM: begin
                    // Whatever phase was in progress at arming is discarded;
                    // measurement starts on a clean rising edge.
                    if (rise) begin
                        state_next = ST_HIGH;
                        run_next   = RUN_ONE;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        hi_tmp_next = run_reg;
                        run_next    = RUN_ONE;
                        state_next  = ST_LOW;
                    end else if (div_clk) begin
                        if (run_reg == RUN_MAX) begin
                            timeout_next = 1'b1;
                            locked_next  = 1'b0;
                            match_next   = 4'd0;
                            run_next     = '0;
                            state_next   = ST_ARM;
                        end else begin
                            run_next = run_reg + RUN_ONE;
                        end
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        high_len_next   = hi_tmp_reg;
                        low_len_next    = run_reg;
                        period_len_next = {1'b0, hi_tmp_reg} + {1'b0, run_reg};
                        mv_next         = 1'b1;
                        run_next        = RUN_ONE;
                        state_next      = ST_HIGH;
                        if (same_meas) begin
                            match_upd = (match_reg >= LOCK_TGT) ? LOCK_TGT
                                                                : match_reg + 4'd1;
                        end else begin
                            match_upd = 4'd1;
                        end
                        match_next  = match_upd;
                        locked_next = (match_upd == LOCK_TGT);
                    end else if (!div_clk) begin
                        if (run_reg == RUN_MAX) begin
                            timeout_next = 1'b1;
                            locked_next  = 1'b0;
                            match_next   = 4'd0;
                            run_next     = '0;
                            state_next   = ST_ARM;
                        end else begin
                            run_next = run_reg + RUN_ONE;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            s_reg          <= 1'b0;
            run_reg        <= '0;
            hi_tmp_reg     <= '0;
            high_len_reg   <= '0;
            low_len_reg    <= '0;
            period_len_reg <= '0;
            match_reg      <= 4'd0;
            locked_reg     <= 1'b0;
            timeout_reg    <= 1'b0;
            mv_reg         <= 1'b0;
            rise_tick_reg  <= 1'b0;
            fall_tick_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            s_reg          <= div_clk;
            run_reg        <= run_next;
            hi_tmp_reg     <= hi_tmp_next;
            high_len_reg   <= high_len_next;
            low_len_reg    <= low_len_next;
            period_len_reg <= period_len_next;
            match_reg      <= match_next;
            locked_reg     <= locked_next;
            timeout_reg    <= timeout_next;
            mv_reg         <= mv_next;
            rise_tick_reg  <= rise_tick_next;
            fall_tick_reg  <= fall_tick_next;
        end
    end

    assign rise_tick  = rise_tick_reg;
    assign fall_tick  = fall_tick_reg;
    assign high_len   = high_len_reg;
    assign low_len    = low_len_reg;
    assign period_len = period_len_reg;
    assign meas_valid = mv_reg;
    assign locked     = locked_reg;
    assign timeout    = timeout_reg;

endmodule

// File: tb/tb_div_clk_monitor.sv
// ---------------------------------------------------------------------------
// tb_div_clk_monitor
//
// Directed-vector bench for div_clk_monitor. Two instances share the same
// stimulus: dut (LOCK_CNT=2) and dut3 (LOCK_CNT=3). A behavioural model
// tracks the cycle indices of the divided-clock edges and derives lengths as
// index differences; lock is judged from a history of measurements. Every
// cycle the outputs are compared against the model, and a set of literal
// expectations pins the model at the key points of each scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_div_clk_monitor;

    localparam int W      = 8;
    localparam int MAXRUN = (1 << W) - 1;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         en      = 1'b0;
    logic         div_clk = 1'b0;

    logic         rise_tick,  fall_tick,  meas_valid,  locked,  timeout;
    logic [W-1:0] high_len,   low_len;
    logic [W:0]   period_len;
    logic         rise_tick3, fall_tick3, meas_valid3, locked3, timeout3;
    logic [W-1:0] high_len3,  low_len3;
    logic [W:0]   period_len3;

    div_clk_monitor #(.CNT_W(W), .LOCK_CNT(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .div_clk(div_clk),
        .rise_tick(rise_tick), .fall_tick(fall_tick),
        .high_len(high_len), .low_len(low_len), .period_len(period_len),
        .meas_valid(meas_valid), .locked(locked), .timeout(timeout)
    );

    div_clk_monitor #(.CNT_W(W), .LOCK_CNT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .div_clk(div_clk),
        .rise_tick(rise_tick3), .fall_tick(fall_tick3),
        .high_len(high_len3), .low_len(low_len3), .period_len(period_len3),
        .meas_valid(meas_valid3), .locked(locked3), .timeout(timeout3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: edge indices and a measurement history.
    // ------------------------------------------------------------------
    int     k           = 0;
    bit     m_armed     = 0;
    bit     m_prev_s    = 0;
    bit     m_track     = 0;
    bit     m_in_high   = 0;
    int     m_last_rise = 0;
    int     m_last_fall = 0;
    int     m_hist[$];
    logic   m_rise_t = 0, m_fall_t = 0, m_mv = 0, m_lock2 = 0, m_lock3 = 0, m_to = 0;
    logic [W-1:0] m_hl = '0, m_ll = '0;
    logic [W:0]   m_pl = '0;

    function automatic logic lock_of(input int n);
        int sz;
        sz = m_hist.size();
        if (sz < n) return 1'b0;
        for (int i = 1; i < n; i++)
            if (m_hist[sz-1-i] != m_hist[sz-1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_lose_track();
        m_track = 0;
        m_hist.delete();
        m_lock2 = 0;
        m_lock3 = 0;
    endtask

    task automatic model_reset();
        m_armed = 0; m_prev_s = 0; m_in_high = 0;
        model_lose_track();
        m_rise_t = 0; m_fall_t = 0; m_mv = 0; m_to = 0;
        m_hl = '0; m_ll = '0; m_pl = '0;
    endtask

    task automatic model_step(input logic e, input logic d);
        bit r, f;
        int hl, ll;
        k++;
        r = d && !m_prev_s;
        f = !d && m_prev_s;
        m_rise_t = 0; m_fall_t = 0; m_mv = 0;
        if (!e) begin
            m_armed = 0;
            m_to    = 0;
            model_lose_track();
        end else if (!m_armed) begin
            m_armed = 1;
            model_lose_track();
        end else begin
            m_rise_t = r;
            m_fall_t = f;
            if (!m_track) begin
                if (r) begin
                    m_track = 1; m_in_high = 1; m_last_rise = k;
                end
            end else if (m_in_high) begin
                if (f) begin
                    m_in_high = 0; m_last_fall = k;
                end else if (k - m_last_rise >= MAXRUN) begin
                    m_to = 1; model_lose_track();
                end
            end else begin
                if (r) begin
                    hl = m_last_fall - m_last_rise;
                    ll = k - m_last_fall;
                    m_hl = hl[W-1:0];
                    m_ll = ll[W-1:0];
                    m_pl = (W+1)'(hl + ll);
                    m_mv = 1;
                    m_hist.push_back(hl * 1024 + ll);
                    if (m_hist.size() > 16) void'(m_hist.pop_front());
                    m_lock2 = lock_of(2);
                    m_lock3 = lock_of(3);
                    m_in_high = 1; m_last_rise = k;
                end else if (k - m_last_fall >= MAXRUN) begin
                    m_to = 1; model_lose_track();
                end
            end
        end
        m_prev_s = d;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step(en, div_clk);
        end
    end

    // ------------------------------------------------------------------
    // Compare process plus event recording.
    // ------------------------------------------------------------------
    int mv_n = 0;
    int mv_cyc[64];
    int mv_lock[64];
    int mv_lock3[64];
    int to_cyc = -1;
    logic to_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("rise_tick",  rise_tick,  m_rise_t);
                check("fall_tick",  fall_tick,  m_fall_t);
                check("meas_valid", meas_valid, m_mv);
                check("high_len",   high_len,   m_hl);
                check("low_len",    low_len,    m_ll);
                check("period_len", period_len, m_pl);
                check("locked",     locked,     m_lock2);
                check("timeout",    timeout,    m_to);
                check("tick_overlap", rise_tick & fall_tick, 1'b0);
                check("locked3",    locked3,    m_lock3);
                check("meas_valid3", meas_valid3, m_mv);
                check("period_len3", {rise_tick3, fall_tick3, timeout3, high_len3, low_len3, period_len3},
                      {m_rise_t, m_fall_t, m_to, m_hl, m_ll, m_pl});
                if (meas_valid && mv_n < 64) begin
                    mv_cyc[mv_n]   = cyc;
                    mv_lock[mv_n]  = int'(locked);
                    mv_lock3[mv_n] = int'(locked3);
                    mv_n++;
                end
                if (timeout && !to_prev) to_cyc = cyc;
                to_prev = timeout;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int drv_cyc = 0;
    int en_cyc  = 0;
    int hold_cyc = 0;

    task automatic drive(input logic en_v, input logic d_v);
        @(negedge clk);
        #1;
        en      = en_v;
        div_clk = d_v;
        drv_cyc = cyc;
    endtask

    task automatic pattern(input logic en_v, input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) drive(en_v, 1'b1);
            for (int i = 0; i < lo; i++) drive(en_v, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) drive(1'b0, 1'b0);
        check("rst_meas_valid", meas_valid, 1'b0);
        check("rst_locked",     locked,     1'b0);
        check("rst_timeout",    timeout,    1'b0);
        check("rst_high_len",   high_len,   0);
        check("rst_period_len", period_len, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        drive(1'b0, 1'b0);

        // 3/5 from enable; the rise coinciding with enable is not measured
        mv_n = 0;
        drive(1'b1, 1'b1);
        en_cyc = drv_cyc;
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        repeat (5) drive(1'b1, 1'b0);
        pattern(1'b1, 3, 5, 4);
        check("a_mv_count",   mv_n, 3);
        check("a_first_mv",   mv_cyc[0] - en_cyc, 17);
        check("a_mv_spacing", mv_cyc[1] - mv_cyc[0], 8);
        check("a_lock_mv1",   mv_lock[0], 0);
        check("a_lock_mv2",   mv_lock[1], 1);
        check("a_lock3_mv2",  mv_lock3[1], 0);
        check("a_lock3_mv3",  mv_lock3[2], 1);
        check("a_high_len",   high_len, 3);
        check("a_low_len",    low_len, 5);
        check("a_period_len", period_len, 8);

        // Switch to 4/4
        mv_n = 0;
        pattern(1'b1, 4, 4, 4);
        check("b_mv_count",  mv_n, 4);
        check("b_lock_35",   mv_lock[0], 1);
        check("b_lock_44_1", mv_lock[1], 0);
        check("b_lock_44_2", mv_lock[2], 1);
        check("b_lock3_44_2", mv_lock3[2], 0);
        check("b_lock3_44_3", mv_lock3[3], 1);
        check("b_period_len", period_len, 8);

        // Toggle every cycle
        mv_n = 0;
        pattern(1'b1, 1, 1, 6);
        check("c_high_len",   high_len, 1);
        check("c_low_len",    low_len, 1);
        check("c_period_len", period_len, 2);
        check("c_mv_spacing", mv_cyc[2] - mv_cyc[1], 2);
        check("c_locked",     locked, 1'b1);

        // Stuck high for 300 cycles
        mv_n = 0;
        to_cyc = -1;
        drive(1'b1, 1'b1);
        hold_cyc = drv_cyc;
        repeat (299) drive(1'b1, 1'b1);
        check("d_timeout_cycle", to_cyc - hold_cyc, 256);
        check("d_timeout",   timeout, 1'b1);
        check("d_locked",    locked, 1'b0);
        check("d_mv_count",  mv_n, 1);

        // Resume 3/5; timeout stays set
        mv_n = 0;
        pattern(1'b1, 3, 5, 4);
        check("e_mv_count",  mv_n, 2);
        check("e_lock_mv1",  mv_lock[0], 0);
        check("e_lock_mv2",  mv_lock[1], 1);
        check("e_timeout",   timeout, 1'b1);
        check("e_high_len",  high_len, 3);

        // Drop en mid-low; lengths hold, no measurements
        repeat (3) drive(1'b1, 1'b1);
        repeat (2) drive(1'b1, 1'b0);
        mv_n = 0;
        repeat (3) drive(1'b0, 1'b0);
        pattern(1'b0, 4, 4, 2);
        check("f_mv_count",   mv_n, 0);
        check("f_high_len",   high_len, 3);
        check("f_low_len",    low_len, 5);
        check("f_period_len", period_len, 8);
        check("f_timeout",    timeout, 1'b0);
        check("f_locked",     locked, 1'b0);

        // Enable in the middle of a high phase
        mv_n = 0;
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        en_cyc = drv_cyc;
        drive(1'b1, 1'b1);
        repeat (5) drive(1'b1, 1'b0);
        pattern(1'b1, 3, 5, 3);
        check("g_mv_count", mv_n, 2);
        check("g_first_mv", mv_cyc[0] - en_cyc, 16);
        check("g_locked",   locked, 1'b1);

        // Asynchronous reset in the middle of a low phase
        repeat (3) drive(1'b1, 1'b1);
        repeat (2) drive(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("h_rise_tick",  rise_tick, 1'b0);
        check("h_fall_tick",  fall_tick, 1'b0);
        check("h_meas_valid", meas_valid, 1'b0);
        check("h_locked",     locked, 1'b0);
        check("h_locked3",    locked3, 1'b0);
        check("h_timeout",    timeout, 1'b0);
        check("h_high_len",   high_len, 0);
        check("h_low_len",    low_len, 0);
        check("h_period_len", period_len, 0);
        repeat (2) drive(1'b0, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) drive(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
